// File: rtl/pwm_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_pkg
// Description : Shared definitions for the PWM configuration path. Contains
//               the default period length, the commit FSM state encoding, the
//               packed 68-bit PWM configuration record and the SPI register
//               addresses of the nine configuration registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_cfg_pkg;

    // Last period_cnt value before wrap; the period is this value + 1 ticks.
    localparam int c_period_max = 254;

    // Commit sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_COMMIT  = 2'd2
    } commit_state_t;

    // Full PWM configuration record (9 fields, 68 bits). This record is shared
    // with spi_peripheral and the PWM generators.
    typedef struct packed {
        logic [7:0] en_out;
        logic [7:0] en_pwm_out;
        logic [7:0] out_3_0_sel;
        logic [7:0] out_7_4_sel;
        logic [7:0] duty_1;
        logic [7:0] duty_2;
        logic [7:0] duty_3;
        logic [7:0] duty_4;
        logic [3:0] freq_div;
    } pwm_cfg_t;

    // SPI register map
    localparam logic [7:0] c_addr_en_out      = 8'h00;
    localparam logic [7:0] c_addr_en_pwm_out  = 8'h01;
    localparam logic [7:0] c_addr_out_3_0_sel = 8'h02;
    localparam logic [7:0] c_addr_out_7_4_sel = 8'h03;
    localparam logic [7:0] c_addr_duty_1      = 8'h04;
    localparam logic [7:0] c_addr_duty_2      = 8'h05;
    localparam logic [7:0] c_addr_duty_3      = 8'h06;
    localparam logic [7:0] c_addr_duty_4      = 8'h07;
    localparam logic [7:0] c_addr_freq_div    = 8'h08;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : PWM timebase. The prescaler divides clk by 2^freq_div to form
//               pwm_tick, and the 8-bit period counter advances on each tick
//               and wraps after PERIOD_MAX. restart clears both counters
//               without producing a period_start.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               freq_div     in  4  - committed divider exponent
//               restart      in  1  - clear prescaler and period counter
//               pwm_tick     out 1  - one-cycle prescaler tick
//               period_cnt   out 8  - current phase, 0..PERIOD_MAX
//               boundary     out 1  - tick on the last phase of the period
//               period_start out 1  - registered, high while phase is 0
//                                     right after a wrap
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase #(
    parameter int PERIOD_MAX = 254,
    parameter int PRESC_W    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] freq_div,
    input  logic       restart,
    output logic       pwm_tick,
    output logic [7:0] period_cnt,
    output logic       boundary,
    output logic       period_start
);

    localparam logic [PRESC_W-1:0] c_presc_one = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]         c_cnt_max   = 8'(PERIOD_MAX);

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_period;
    logic               r_period_start;
    logic [PRESC_W-1:0] w_presc_lim;

    // Terminal prescaler count is 2^freq_div - 1.
    assign w_presc_lim  = PRESC_W'((32'd1 << freq_div) - 32'd1);
    assign pwm_tick     = (r_presc == w_presc_lim);
    assign boundary     = pwm_tick && (r_period == c_cnt_max);
    assign period_cnt   = r_period;
    assign period_start = r_period_start;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_presc        <= '0;
            r_period       <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_presc        <= pwm_tick ? '0 : (r_presc + c_presc_one);
            r_period_start <= boundary;
            if (pwm_tick) begin
                r_period <= (r_period == c_cnt_max) ? 8'd0 : (r_period + 8'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_config_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_config_commit_ctrl
// Description : Holds shadow copies of the nine PWM configuration registers
//               and commits the live SPI values into them atomically, only on
//               a PWM period boundary (or immediately on force_commit), so
//               the PWM datapath never sees a mid-period change.
// Ports       : clk, rst                   - clock, sync active-high reset
//               live_*              in     - live SPI register values
//               hold                in  1  - level, blocks boundary commits
//               force_commit        in  1  - immediate commit, timebase restart
//               sh_*                out    - committed values to datapath
//               period_cnt          out 8  - PWM phase
//               pwm_tick            out 1  - prescaler tick
//               period_start        out 1  - first cycle of a new period
//               commit_pulse        out 1  - cycle after shadows update
//               pending             out 1  - live differs or commit deferred
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_config_commit_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int PERIOD_MAX = 254,
    parameter int PRESC_W    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] live_en_out,
    input  logic [7:0] live_en_pwm_out,
    input  logic [7:0] live_out_3_0_sel,
    input  logic [7:0] live_out_7_4_sel,
    input  logic [7:0] live_duty_1,
    input  logic [7:0] live_duty_2,
    input  logic [7:0] live_duty_3,
    input  logic [7:0] live_duty_4,
    input  logic [3:0] live_freq_div,
    input  logic       hold,
    input  logic       force_commit,
    output logic [7:0] sh_en_out,
    output logic [7:0] sh_en_pwm_out,
    output logic [7:0] sh_out_3_0_sel,
    output logic [7:0] sh_out_7_4_sel,
    output logic [7:0] sh_duty_1,
    output logic [7:0] sh_duty_2,
    output logic [7:0] sh_duty_3,
    output logic [7:0] sh_duty_4,
    output logic [3:0] sh_freq_div,
    output logic [7:0] period_cnt,
    output logic       pwm_tick,
    output logic       period_start,
    output logic       commit_pulse,
    output logic       pending
);

    pwm_cfg_t      w_live;
    pwm_cfg_t      r_sh;
    commit_state_t r_state;
    commit_state_t w_state_nxt;
    logic          w_diff;
    logic          w_boundary;
    logic          w_load;

    assign w_live = {live_en_out, live_en_pwm_out, live_out_3_0_sel,
                     live_out_7_4_sel, live_duty_1, live_duty_2,
                     live_duty_3, live_duty_4, live_freq_div};

    assign w_diff = (w_live != r_sh);

    // The timebase always runs from the committed divider so a new divider
    // only applies from the period following its commit.
    pwm_timebase #(
        .PERIOD_MAX (PERIOD_MAX),
        .PRESC_W    (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .freq_div     (r_sh.freq_div),
        .restart      (force_commit),
        .pwm_tick     (pwm_tick),
        .period_cnt   (period_cnt),
        .boundary     (w_boundary),
        .period_start (period_start)
    );

    // Every shadow field loads from one enable on one edge: no partial commit.
    assign w_load = force_commit ||
                    ((r_state == S_PENDING) && w_boundary && !hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (w_load) begin
            r_sh <= w_live;
        end
    end

    assign sh_en_out      = r_sh.en_out;
    assign sh_en_pwm_out  = r_sh.en_pwm_out;
    assign sh_out_3_0_sel = r_sh.out_3_0_sel;
    assign sh_out_7_4_sel = r_sh.out_7_4_sel;
    assign sh_duty_1      = r_sh.duty_1;
    assign sh_duty_2      = r_sh.duty_2;
    assign sh_duty_3      = r_sh.duty_3;
    assign sh_duty_4      = r_sh.duty_4;
    assign sh_freq_div    = r_sh.freq_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        commit_pulse = 1'b0;
        pending      = w_diff;
        case (r_state)
            S_IDLE: begin
                if (w_diff) begin
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                pending = 1'b1;
                if (w_boundary && !hold) begin
                    w_state_nxt = S_COMMIT;
                end else if (!w_diff) begin
                    // Live value reverted to the committed one.
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                commit_pulse = 1'b1;
                w_state_nxt  = w_diff ? S_PENDING : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Forced commit wins over hold and over a coincident boundary.
        if (force_commit) begin
            w_state_nxt = S_COMMIT;
        end
    end

endmodule
`default_nettype wire
